// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdio_pkg
// Purpose  : Shared widths, constants and FSM encoding for the MDIO arbiter.
// Revision : 1.0
// ============================================================================
package mdio_pkg;

    localparam int MDIO_ADDR_W = 5;
    localparam int MDIO_DATA_W = 16;
    localparam logic [MDIO_DATA_W-1:0] MDIO_ERR_DATA = 16'hFFFF;
    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester index reached by stepping 'offset' places past 'last', wrapping at n.
    function automatic int rr_index(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mdio_arbiter_if
// Purpose  : Requester and MDIO-engine signal bundle around the arbiter.
// Revision : 1.0
// ============================================================================
interface mdio_arbiter_if #(
    parameter int NREQ = 2
);
    import mdio_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_wr;
    logic [MDIO_ADDR_W*NREQ-1:0] req_phy_addr;
    logic [MDIO_ADDR_W*NREQ-1:0] req_reg_addr;
    logic [MDIO_DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             rsp_valid;
    logic [MDIO_DATA_W-1:0]      rsp_rdata;
    logic                        rsp_err;
    logic                        eng_start;
    logic                        eng_wr;
    logic [MDIO_ADDR_W-1:0]      eng_phy_addr;
    logic [MDIO_ADDR_W-1:0]      eng_reg_addr;
    logic [MDIO_DATA_W-1:0]      eng_wdata;
    logic                        eng_done;
    logic [MDIO_DATA_W-1:0]      eng_rdata;
    logic                        busy;

    // The arbiter itself.
    modport slave (
        input  req_valid, req_wr, req_phy_addr, req_reg_addr, req_wdata,
        input  eng_done, eng_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output eng_start, eng_wr, eng_phy_addr, eng_reg_addr, eng_wdata, busy
    );

    // Everything around it: the requesters and the MDIO engine.
    modport master (
        output req_valid, req_wr, req_phy_addr, req_reg_addr, req_wdata,
        output eng_done, eng_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  eng_start, eng_wr, eng_phy_addr, eng_reg_addr, eng_wdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick starting just after last_grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import mdio_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  wire logic [NREQ-1:0]  i_req,
    input  wire logic [IDX_W-1:0] i_last_grant,
    output logic      [NREQ-1:0]  o_grant,
    output logic      [IDX_W-1:0] o_grant_idx,
    output logic                  o_any_req
);

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_req   = |i_req;
        // Scan farthest-first so the nearest requester after last_grant is written last and wins.
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[rr_index(int'(i_last_grant), k, NREQ)]) begin
                o_grant = '0;
                o_grant[rr_index(int'(i_last_grant), k, NREQ)] = 1'b1;
                o_grant_idx = IDX_W'(rr_index(int'(i_last_grant), k, NREQ));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mdio_arbiter
// Purpose  : Round-robin sharing of one MDIO engine with a WAIT-state watchdog.
// Revision : 1.0
// ============================================================================
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input wire logic     clk,
    input wire logic     rst,
    mdio_arbiter_if.slave bus
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = {c_TMR_W{1'b1}};
    localparam logic [c_IDX_W-1:0] c_IDX_RST  = c_IDX_W'(NREQ - 1);

    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_last_grant;
    logic [c_IDX_W-1:0]     r_grant_idx;
    logic [NREQ-1:0]        r_grant_oh;
    logic [c_TMR_W-1:0]     r_timer;
    logic [NREQ-1:0]        r_req_ready;
    logic [NREQ-1:0]        r_rsp_valid;
    logic [MDIO_DATA_W-1:0] r_rsp_rdata;
    logic                   r_rsp_err;
    logic                   r_eng_start;
    logic                   r_eng_wr;
    logic [MDIO_ADDR_W-1:0] r_eng_phy_addr;
    logic [MDIO_ADDR_W-1:0] r_eng_reg_addr;
    logic [MDIO_DATA_W-1:0] r_eng_wdata;
    logic                   r_busy;

    logic [NREQ-1:0]        w_grant;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic                   w_any_req;
    logic                   w_sel_wr;
    logic [MDIO_ADDR_W-1:0] w_sel_phy_addr;
    logic [MDIO_ADDR_W-1:0] w_sel_reg_addr;
    logic [MDIO_DATA_W-1:0] w_sel_wdata;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (c_IDX_W)
    ) u_rr (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_req    (w_any_req)
    );

    assign w_sel_wr       = bus.req_wr[w_grant_idx];
    assign w_sel_phy_addr = bus.req_phy_addr[int'(w_grant_idx)*MDIO_ADDR_W +: MDIO_ADDR_W];
    assign w_sel_reg_addr = bus.req_reg_addr[int'(w_grant_idx)*MDIO_ADDR_W +: MDIO_ADDR_W];
    assign w_sel_wdata    = bus.req_wdata[int'(w_grant_idx)*MDIO_DATA_W +: MDIO_DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_last_grant   <= c_IDX_RST;
            r_grant_idx    <= '0;
            r_grant_oh     <= '0;
            r_timer        <= '0;
            r_req_ready    <= '0;
            r_rsp_valid    <= '0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            r_eng_start    <= 1'b0;
            r_eng_wr       <= 1'b0;
            r_eng_phy_addr <= '0;
            r_eng_reg_addr <= '0;
            r_eng_wdata    <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_eng_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant_idx    <= w_grant_idx;
                        r_grant_oh     <= w_grant;
                        r_req_ready    <= w_grant;
                        r_eng_start    <= 1'b1;
                        r_eng_wr       <= w_sel_wr;
                        r_eng_phy_addr <= w_sel_phy_addr;
                        r_eng_reg_addr <= w_sel_reg_addr;
                        r_eng_wdata    <= w_sel_wdata;
                        r_timer        <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_timer != c_TMR_MAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    // A completion landing on the timeout cycle still counts as success.
                    if (bus.eng_done) begin
                        r_rsp_rdata <= bus.eng_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_grant_oh;
                        r_state     <= DONE;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_rsp_rdata <= MDIO_ERR_DATA;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_grant_oh;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_rsp_valid  <= '0;
                    r_last_grant <= r_grant_idx;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.eng_start    = r_eng_start;
    assign bus.eng_wr       = r_eng_wr;
    assign bus.eng_phy_addr = r_eng_phy_addr;
    assign bus.eng_reg_addr = r_eng_reg_addr;
    assign bus.eng_wdata    = r_eng_wdata;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mdio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_arbiter
// Purpose  : Self-checking bench: vector table, corner sequences, random traffic.
// Revision : 1.0
// ============================================================================
module tb_mdio_arbiter;
    import mdio_pkg::*;

    localparam int c_NREQ = 2;
    localparam int c_TMO  = 64;

    typedef struct {
        logic [1:0]  mask;
        int          lat;
        logic [15:0] rdata;
        int          exp_g;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    mdio_arbiter_if #(.NREQ(c_NREQ)) bus();

    mdio_arbiter #(
        .NREQ        (c_NREQ),
        .TIMEOUT_CYC (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          model_last = c_NREQ - 1;
    logic        f_wr  [c_NREQ];
    logic [4:0]  f_phy [c_NREQ];
    logic [4:0]  f_reg [c_NREQ];
    logic [15:0] f_wd  [c_NREQ];
    vec_t        tbl   [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_fields();
        for (int i = 0; i < c_NREQ; i++) begin
            bus.req_wr[i]              = f_wr[i];
            bus.req_phy_addr[i*5 +: 5] = f_phy[i];
            bus.req_reg_addr[i*5 +: 5] = f_reg[i];
            bus.req_wdata[i*16 +: 16]  = f_wd[i];
        end
    endtask

    // Reference pick: first requesting index after the previous winner, wrapping.
    function automatic int model_grant(input logic [1:0] mask);
        for (int off = 1; off <= c_NREQ; off++) begin
            if (mask[(model_last + off) % c_NREQ]) return (model_last + off) % c_NREQ;
        end
        return -1;
    endfunction

    // Entered and left at one step past a rising edge with the arbiter idle.
    // lat = cycles after eng_start at which eng_done pulses; lat >= c_TMO means never.
    task automatic run_txn(input logic [1:0] mask, input int lat, input logic [15:0] rdata,
                           input int exp_g, input bit keep, input bit glitch);
        int         resp_at;
        bit         early;
        logic [1:0] oh;
        oh      = 2'(1 << exp_g);
        resp_at = (lat < c_TMO) ? lat + 1 : c_TMO;
        bus.req_valid = mask;
        tick();
        check("req_ready", 32'(bus.req_ready), 32'(oh));
        check("eng_start", 32'(bus.eng_start), 32'd1);
        check("eng_fields", {bus.eng_wr, bus.eng_phy_addr, bus.eng_reg_addr, bus.eng_wdata},
              {f_wr[exp_g], f_phy[exp_g], f_reg[exp_g], f_wd[exp_g]});
        check("busy_wait", 32'(bus.busy), 32'd1);
        if (!keep) bus.req_valid = '0;
        early = 1'b0;
        for (int k = 0; k < resp_at; k++) begin
            bus.eng_done  = (k == lat);
            bus.eng_rdata = (k == lat) ? rdata : (16'h0BAD ^ 16'(k));
            if (glitch) bus.req_valid[1] = (k >= 1 && k < 4);
            tick();
            bus.eng_done = 1'b0;
            if (k == 0) check("start_pulse", {bus.eng_start, bus.req_ready}, 32'd0);
            if (k + 1 < resp_at && bus.rsp_valid != '0) early = 1'b1;
        end
        check("no_early_rsp", 32'(early), 32'd0);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        check("rsp_data", {bus.rsp_err, bus.rsp_rdata},
              (lat < c_TMO) ? {1'b0, rdata} : {1'b1, 16'hFFFF});
        tick();
        check("rsp_clear", {bus.rsp_valid, bus.busy}, 32'd0);
        model_last = exp_g;
    endtask

    initial begin
        bit bad;
        bus.req_valid    = '0;
        bus.req_wr       = '0;
        bus.req_phy_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_wdata    = '0;
        bus.eng_done     = 1'b0;
        bus.eng_rdata    = '0;

        tbl[0] = '{2'b01, 40, 16'h796D, 0};
        tbl[1] = '{2'b11,  3, 16'h1234, 1};
        tbl[2] = '{2'b11,  0, 16'h0F0F, 0};
        tbl[3] = '{2'b11,  5, 16'hA5A5, 1};
        tbl[4] = '{2'b11, 70, 16'h0000, 0};
        tbl[5] = '{2'b10, 63, 16'h5555, 1};
        tbl[6] = '{2'b10,  2, 16'h0001, 1};
        tbl[7] = '{2'b01,  1, 16'h8000, 0};
        tbl[8] = '{2'b01, 64, 16'h0000, 0};
        tbl[9] = '{2'b11, 10, 16'hC3C3, 1};

        repeat (3) tick();
        rst = 1'b0;
        check("rst_ctrl", {bus.req_ready, bus.rsp_valid, bus.eng_start, bus.busy, bus.rsp_err}, 32'd0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_eng", {bus.eng_wr, bus.eng_phy_addr, bus.eng_reg_addr, bus.eng_wdata}, 32'd0);

        // Vector table; requester 0 reads, requester 1 writes, requests held continuously.
        f_wr[0] = 1'b0; f_phy[0] = 5'd1; f_reg[0] = 5'd5; f_wd[0] = 16'hA000;
        f_wr[1] = 1'b1; f_phy[1] = 5'd2; f_reg[1] = 5'd9; f_wd[1] = 16'hB111;
        apply_fields();
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].mask, tbl[i].lat, tbl[i].rdata, tbl[i].exp_g, 1'b1, 1'b0);
        end
        bus.req_valid = '0;

        // Requester 1 pulses and withdraws during requester 0's transaction.
        run_txn(2'b01, 20, 16'h2468, 0, 1'b0, 1'b1);
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (bus.req_ready != '0 || bus.busy || bus.rsp_valid != '0) bad = 1'b1;
        end
        check("withdrawn_idle", 32'(bad), 32'd0);

        // Asynchronous reset in WAIT, then requester 0 wins first again.
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = '0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", {bus.req_ready, bus.rsp_valid, bus.eng_start, bus.busy, bus.rsp_err}, 32'd0);
        check("arst_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("arst_eng", {bus.eng_wr, bus.eng_phy_addr, bus.eng_reg_addr, bus.eng_wdata}, 32'd0);
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (bus.rsp_valid != '0) bad = 1'b1;
        end
        rst = 1'b0;
        repeat (2) begin
            tick();
            if (bus.rsp_valid != '0 || bus.busy) bad = 1'b1;
        end
        check("arst_no_rsp", 32'(bad), 32'd0);
        model_last = c_NREQ - 1;
        run_txn(2'b11, 4, 16'h1357, model_grant(2'b11), 1'b0, 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  mask;
            int          lat;
            int          sel;
            for (int i = 0; i < c_NREQ; i++) begin
                f_wr[i]  = 1'($urandom);
                f_phy[i] = 5'($urandom);
                f_reg[i] = 5'($urandom);
                f_wd[i]  = 16'($urandom);
            end
            apply_fields();
            mask = 2'($urandom_range(1, 3));
            sel  = int'($urandom_range(0, 7));
            if (sel < 6)       lat = int'($urandom_range(0, 12));
            else if (sel == 6) lat = c_TMO - 1;
            else               lat = c_TMO + int'($urandom_range(0, 16));
            run_txn(mask, lat, 16'($urandom), model_grant(mask), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
